cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Synthesizable run controller that sits between the board-level clock/reset and the BIP-I core in `cpu_top`. It sequences CPU reset, gates the CPU clock-enable in free-run, single-step or cycle-limited modes, and stops the core on a HALT opcode, a cycle limit or an abort. At stop it snapshots PC/ACC and the executed-cycle count for LEDs/UART readout. It replaces the fixed "hold reset, run N ns, stop" sequencing with parametrised, in-hardware control.

## Interface
Parameters:
- `RST_CYCLES`, 2: cycles the CPU reset is held after start (≥1).
- `CNT_W`, 32: cycle-counter width.
- `MAX_CYCLES`, 0: limit used in LIMIT mode; 0 = unlimited.
- `PC_W`, 11: PC width.
- `INST_W`, 16: instruction width.
- `ACC_W`, 16: accumulator width.
- `OPC_W`, 5: opcode width, taken as `i_inst[INST_W-1 -: OPC_W]`.
- `HALT_OPC`, 5'b00000: opcode that stops the run.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_start`  in  1  one-cycle pulse; begin a run (accepted in IDLE/DONE).
- `i_mode`  in  2  0 FREE, 1 STEP, 2 LIMIT; sampled only on an accepted start.
- `i_step`  in  1  one-cycle pulse; execute one instruction in STEP mode.
- `i_abort`  in  1  one-cycle pulse; stop the run.
- `i_pc`  in  PC_W  CPU program counter.
- `i_inst`  in  INST_W  instruction currently executing.
- `i_acc`  in  ACC_W  CPU accumulator.
- `o_cpu_rst`  out  1  CPU synchronous reset.
- `o_cpu_en`  out  1  CPU clock-enable.
- `o_busy`  out  1  state is RESET, RUN or STEP.
- `o_done`  out  1  state is DONE.
- `o_cause`  out  2  0 NONE, 1 HALT, 2 LIMIT, 3 ABORT.
- `o_cycles`  out  CNT_W  enabled cycles in the current run.
- `o_last_pc`  out  PC_W  PC captured on the stop.
- `o_last_acc`  out  ACC_W  ACC captured on the stop.

## Operation
- States: IDLE, RESET, RUN, STEP, DONE.
- **IDLE**: `o_cpu_rst`=1, `o_cpu_en`=0. On `i_start`, latch the mode, clear `o_cycles` and `o_cause`, and go to RESET.
- **RESET**: `o_cpu_rst`=1 for exactly RST_CYCLES cycles. Then go to STEP if the mode is STEP, else to RUN.
- **RUN**: `o_cpu_rst`=0, `o_cpu_en`=1 every cycle.
- **STEP**: `o_cpu_rst`=0. `o_cpu_en`=1 only in the cycle following an `i_step` pulse. Pulses arriving while that enable is high are ignored.
- Cycle counter: `o_cycles` +1 on every cycle with `o_cpu_en`=1. It saturates at all-ones and does not wrap.
- Stop conditions, evaluated in an enabled cycle, priority ABORT > HALT > LIMIT:
  - HALT: the opcode equals HALT_OPC.
  - LIMIT: mode is LIMIT, MAX_CYCLES≠0, and this enabled cycle is number MAX_CYCLES, i.e. `o_cycles`==MAX_CYCLES-1 before the increment.
  - ABORT: `i_abort` in any of RESET, RUN or STEP, regardless of enable.
- On a stop: next state is DONE; set `o_cause`; capture `i_pc`/`i_acc` into `o_last_pc`/`o_last_acc` at the same edge.
- **DONE**: `o_cpu_en`=0, `o_cpu_rst`=0 (the CPU keeps its state for inspection). All outputs are held. `i_start` restarts via RESET. `i_step` and `i_abort` are ignored.
- Simultaneous events:
  - `i_start` in RESET/RUN/STEP is ignored.
  - `i_start` together with `i_abort` in DONE: the start wins.

## Timing
- Reset values: state IDLE, `o_cpu_rst`=1, `o_cpu_en`=0, `o_busy`=0, `o_done`=0, `o_cause`=0, `o_cycles`=0, `o_last_pc`=0, `o_last_acc`=0.
- All outputs are registered; there is no combinational input-to-output path.
- Start is accepted at edge k. The state is RESET during cycles k+1 … k+RST_CYCLES. `o_cpu_en` first goes high in cycle k+RST_CYCLES+1 (FREE/LIMIT).
- Stop detected in enabled cycle j: `o_cpu_en`=0 and `o_done`=1 from cycle j+1. The instruction of cycle j is the last one executed, and `o_cycles` includes it.
- STEP: an `i_step` pulse in cycle s gives `o_cpu_en`=1 in cycle s+1 only.
- `i_rst` mid-run: immediate asynchronous return to reset values. `o_cpu_rst`=1 asynchronously.

## Structure
- Package `cpu_run_pkg`:
  - state encoding;
  - mode constants FREE/STEP/LIMIT;
  - cause constants NONE/HALT/LIMIT/ABORT.
- One sub-module `cpu_run_cnt`: a CNT_W saturating counter with sync clear and enable, also used for the RESET countdown (second instance).
- The controller FSM and snapshot registers live in `cpu_run_ctrl`.

## Test plan
- FREE, RST_CYCLES=2. HALT (opcode 0) appears at the 6th enabled cycle with PC=5, ACC=16'h0007. Required: `o_cpu_en` high for exactly 6 cycles; `o_cycles`=6; `o_cause`=1; `o_last_pc`=5; `o_last_acc`=16'h0007.
- LIMIT, MAX_CYCLES=10, no HALT opcode. Required: exactly 10 enable cycles; `o_cycles`=10; `o_cause`=2. Repeat with MAX_CYCLES=0 and abort at enable cycle 50: `o_cause`=3, `o_cycles`=50.
- STEP: 3 `i_step` pulses spaced 4 cycles apart, plus one pulse landing on an enabled cycle. Required: 3 single-cycle enables; `o_cycles`=3.
- Simultaneous: HALT opcode and `i_abort` in the same cycle. Required: `o_cause`=3. `i_start` in RUN has no effect. `i_start`+`i_abort` in DONE gives RESET.
- `i_rst` asserted mid-RUN at `o_cycles`=7. Required: all outputs at reset values immediately; a following start counts from 0.
- Saturation with CNT_W=4, FREE, no HALT for 20 cycles, then abort. Required: `o_cycles`=4'hF.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run controller: FSM encoding,
// run modes and stop causes.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StRun,
    StStep,
    StDone
  } run_state_e;

  localparam logic [1:0] ModeFree  = 2'd0;
  localparam logic [1:0] ModeStep  = 2'd1;
  localparam logic [1:0] ModeLimit = 2'd2;

  localparam logic [1:0] CauseNone  = 2'd0;
  localparam logic [1:0] CauseHalt  = 2'd1;
  localparam logic [1:0] CauseLimit = 2'd2;
  localparam logic [1:0] CauseAbort = 2'd3;

  function automatic logic is_busy(run_state_e s);
    return (s == StReset) || (s == StRun) || (s == StStep);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/observation bundle between the board-side sequencer (master) and
// the run controller (slave).
interface cpu_run_ctrl_if #(
  parameter int unsigned PC_W   = 11,
  parameter int unsigned INST_W = 16,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned CNT_W  = 32
);
  logic              i_start;
  logic [1:0]        i_mode;
  logic              i_step;
  logic              i_abort;
  logic [PC_W-1:0]   i_pc;
  logic [INST_W-1:0] i_inst;
  logic [ACC_W-1:0]  i_acc;
  logic              o_cpu_rst;
  logic              o_cpu_en;
  logic              o_busy;
  logic              o_done;
  logic [1:0]        o_cause;
  logic [CNT_W-1:0]  o_cycles;
  logic [PC_W-1:0]   o_last_pc;
  logic [ACC_W-1:0]  o_last_acc;

  modport master (
    output i_start, i_mode, i_step, i_abort, i_pc, i_inst, i_acc,
    input  o_cpu_rst, o_cpu_en, o_busy, o_done, o_cause, o_cycles, o_last_pc, o_last_acc
  );

  modport slave (
    input  i_start, i_mode, i_step, i_abort, i_pc, i_inst, i_acc,
    output o_cpu_rst, o_cpu_en, o_busy, o_done, o_cause, o_cycles, o_last_pc, o_last_acc
  );
endinterface

// File: rtl/cpu_run_cnt.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module cpu_run_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);
  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the BIP-I core: sequences CPU reset, gates the clock
// enable (free/step/limit) and snapshots PC/ACC/cycle count on stop.
module cpu_run_ctrl #(
  parameter int unsigned      RST_CYCLES = 2,
  parameter int unsigned      CNT_W      = 32,
  parameter int unsigned      MAX_CYCLES = 0,
  parameter int unsigned      PC_W       = 11,
  parameter int unsigned      INST_W     = 16,
  parameter int unsigned      ACC_W      = 16,
  parameter int unsigned      OPC_W      = 5,
  parameter logic [OPC_W-1:0] HALT_OPC   = '0
) (
  input logic           i_clk,
  input logic           i_rst,
  cpu_run_ctrl_if.slave bus
);
  import cpu_run_pkg::*;

  // Reset countdown only needs to reach RST_CYCLES-1.
  localparam int unsigned      RstW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RstW-1:0]  RstLast   = RstW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LimitLast = CNT_W'(MAX_CYCLES - 1);

  run_state_e       state_d, state_q;
  logic [1:0]       mode_d, mode_q;
  logic [1:0]       cause_d, cause_q;
  logic [PC_W-1:0]  last_pc_d, last_pc_q;
  logic [ACC_W-1:0] last_acc_d, last_acc_q;
  logic             cpu_en_d, cpu_en_q;
  logic             cpu_rst_d, cpu_rst_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;

  logic [CNT_W-1:0] cycles;
  logic [RstW-1:0]  rst_cnt;
  logic             start_ok;
  logic             halt_hit;
  logic             limit_hit;
  logic             stop;
  logic [1:0]       stop_cause;
  logic             unused_inst;

  assign start_ok  = bus.i_start && ((state_q == StIdle) || (state_q == StDone));
  assign halt_hit  = cpu_en_q && (bus.i_inst[INST_W-1 -: OPC_W] == HALT_OPC);
  assign limit_hit = cpu_en_q && (mode_q == ModeLimit) && (MAX_CYCLES != 0) &&
                     (cycles == LimitLast);
  assign stop       = bus.i_abort || halt_hit || limit_hit;
  assign stop_cause = bus.i_abort ? CauseAbort : (halt_hit ? CauseHalt : CauseLimit);
  assign unused_inst = ^bus.i_inst[INST_W-OPC_W-1:0];

  cpu_run_cnt #(
    .Width(CNT_W)
  ) u_cycle_cnt (
    .clk_i(i_clk),
    .rst_i(i_rst),
    .clr_i(start_ok),
    .en_i (cpu_en_q),
    .cnt_o(cycles)
  );

  cpu_run_cnt #(
    .Width(RstW)
  ) u_reset_cnt (
    .clk_i(i_clk),
    .rst_i(i_rst),
    .clr_i(start_ok),
    .en_i (state_q == StReset),
    .cnt_o(rst_cnt)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cause_d    = cause_q;
    last_pc_d  = last_pc_q;
    last_acc_d = last_acc_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.i_start) begin
          state_d = StReset;
          mode_d  = bus.i_mode;
          cause_d = CauseNone;
        end
      end
      StReset, StRun, StStep: begin
        if (stop) begin
          state_d    = StDone;
          cause_d    = stop_cause;
          last_pc_d  = bus.i_pc;
          last_acc_d = bus.i_acc;
        end else if ((state_q == StReset) && (rst_cnt == RstLast)) begin
          state_d = (mode_q == ModeStep) ? StStep : StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with it.
    cpu_en_d  = (state_d == StRun) ||
                ((state_q == StStep) && (state_d == StStep) && bus.i_step && !cpu_en_q);
    cpu_rst_d = (state_d == StIdle) || (state_d == StReset);
    busy_d    = is_busy(state_d);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      mode_q     <= ModeFree;
      cause_q    <= CauseNone;
      last_pc_q  <= '0;
      last_acc_q <= '0;
      cpu_en_q   <= 1'b0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cause_q    <= cause_d;
      last_pc_q  <= last_pc_d;
      last_acc_q <= last_acc_d;
      cpu_en_q   <= cpu_en_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_cpu_rst  = cpu_rst_q;
  assign bus.o_cpu_en   = cpu_en_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_cause    = cause_q;
  assign bus.o_cycles   = cycles;
  assign bus.o_last_pc  = last_pc_q;
  assign bus.o_last_acc = last_acc_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: three configurations share one stimulus stream and
// are compared each cycle against a run-level model of the controller rules.
module tb_cpu_run_ctrl;
  localparam int unsigned R = 2;
  localparam bit [1:0] MFree = 2'd0, MStep = 2'd1, MLimit = 2'd2;

  typedef struct packed {
    logic        cpu_rst;
    logic        cpu_en;
    logic        busy;
    logic        done;
    logic [1:0]  cause;
    logic [31:0] cycles;
    logic [10:0] pc;
    logic [15:0] acc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, step, abort;
  logic [1:0]  mode;
  logic [10:0] pc;
  logic [15:0] inst, acc;

  int vectors = 0;
  int miscompares = 0;

  // Model state, one slot per configuration (a: limit 10, b: unlimited, c: 4-bit counter).
  bit          run_m[3], done_m[3], en_m[3], stq_m[3];
  int unsigned cnt_m[3];
  logic [1:0]  cause_m[3];
  logic [10:0] pc_m[3];
  logic [15:0] acc_m[3];
  int unsigned cap_m[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd15};
  int unsigned max_m[3] = '{32'd10, 32'd0, 32'd0};
  int          en_seen[3];
  bit [1:0]    mode_m = 2'd0;
  int          t_m = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.PC_W(11), .INST_W(16), .ACC_W(16), .CNT_W(32)) ifa ();
  cpu_run_ctrl_if #(.PC_W(11), .INST_W(16), .ACC_W(16), .CNT_W(32)) ifb ();
  cpu_run_ctrl_if #(.PC_W(11), .INST_W(16), .ACC_W(16), .CNT_W(4))  ifc ();

  assign ifa.i_start = start;  assign ifa.i_mode = mode;  assign ifa.i_step = step;
  assign ifa.i_abort = abort;  assign ifa.i_pc = pc;  assign ifa.i_inst = inst;
  assign ifa.i_acc = acc;
  assign ifb.i_start = start;  assign ifb.i_mode = mode;  assign ifb.i_step = step;
  assign ifb.i_abort = abort;  assign ifb.i_pc = pc;  assign ifb.i_inst = inst;
  assign ifb.i_acc = acc;
  assign ifc.i_start = start;  assign ifc.i_mode = mode;  assign ifc.i_step = step;
  assign ifc.i_abort = abort;  assign ifc.i_pc = pc;  assign ifc.i_inst = inst;
  assign ifc.i_acc = acc;

  cpu_run_ctrl #(.RST_CYCLES(2), .CNT_W(32), .MAX_CYCLES(10)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(ifa)
  );
  cpu_run_ctrl #(.RST_CYCLES(2), .CNT_W(32), .MAX_CYCLES(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(ifb)
  );
  cpu_run_ctrl #(.RST_CYCLES(2), .CNT_W(4), .MAX_CYCLES(0)) dut_c (
    .i_clk(clk), .i_rst(rst), .bus(ifc)
  );

  function automatic obs_t observe(input int d);
    obs_t o;
    case (d)
      0: o = {ifa.o_cpu_rst, ifa.o_cpu_en, ifa.o_busy, ifa.o_done, ifa.o_cause,
              ifa.o_cycles, ifa.o_last_pc, ifa.o_last_acc};
      1: o = {ifb.o_cpu_rst, ifb.o_cpu_en, ifb.o_busy, ifb.o_done, ifb.o_cause,
              ifb.o_cycles, ifb.o_last_pc, ifb.o_last_acc};
      default: o = {ifc.o_cpu_rst, ifc.o_cpu_en, ifc.o_busy, ifc.o_done, ifc.o_cause,
                    28'd0, ifc.o_cycles, ifc.o_last_pc, ifc.o_last_acc};
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d t=%0d: observed %0h expected %0h", tag, d, t_m, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      run_m[d] = 1'b0;  done_m[d] = 1'b0;  en_m[d] = 1'b0;  stq_m[d] = 1'b0;
      cnt_m[d] = 0;  cause_m[d] = 2'd0;  pc_m[d] = '0;  acc_m[d] = '0;
    end
    t_m = 0;
  endtask

  task automatic idle_inputs();
    start = 1'b0;  step = 1'b0;  abort = 1'b0;
  endtask

  task automatic rand_cpu();
    inst = {5'($urandom_range(31, 1)), 11'($urandom)};
    pc   = 11'($urandom);
    acc  = 16'($urandom);
  endtask

  // Expected outputs for the current cycle, then compare all of them.
  task automatic check_cycle();
    obs_t o;
    for (int d = 0; d < 3; d++) begin
      en_m[d] = run_m[d] && (t_m > int'(R)) && ((mode_m != MStep) || stq_m[d]);
      o = observe(d);
      if (o.cpu_en === 1'b1) en_seen[d]++;
      chk("cpu_en", d, 32'(o.cpu_en), 32'(en_m[d]));
      chk("cpu_rst", d, 32'(o.cpu_rst),
          32'((!run_m[d] && !done_m[d]) || (run_m[d] && t_m <= int'(R))));
      chk("busy", d, 32'(o.busy), 32'(run_m[d]));
      chk("done", d, 32'(o.done), 32'(done_m[d]));
      chk("cause", d, 32'(o.cause), 32'(cause_m[d]));
      chk("cycles", d, o.cycles, cnt_m[d]);
      chk("last_pc", d, 32'(o.pc), 32'(pc_m[d]));
      chk("last_acc", d, 32'(o.acc), 32'(acc_m[d]));
    end
  endtask

  // Apply the rules to the inputs of the current cycle.
  task automatic update();
    bit       stop;
    bit [1:0] cs;
    bit       started = 1'b0;
    for (int d = 0; d < 3; d++) begin
      if (run_m[d]) begin
        stop = 1'b1;
        if (abort) cs = 2'd3;
        else if (en_m[d] && inst[15:11] == 5'd0) cs = 2'd1;
        else if (en_m[d] && mode_m == MLimit && max_m[d] != 0 && cnt_m[d] == max_m[d] - 1)
          cs = 2'd2;
        else begin
          stop = 1'b0;
          cs = 2'd0;
        end
        if (en_m[d] && cnt_m[d] < cap_m[d]) cnt_m[d]++;
        stq_m[d] = !stop && t_m > int'(R) && mode_m == MStep && step && !en_m[d];
        if (stop) begin
          run_m[d] = 1'b0;  done_m[d] = 1'b1;  cause_m[d] = cs;  pc_m[d] = pc;  acc_m[d] = acc;
        end
      end else if (start) begin
        run_m[d] = 1'b1;  done_m[d] = 1'b0;  cnt_m[d] = 0;  cause_m[d] = 2'd0;  stq_m[d] = 1'b0;
        started = 1'b1;
      end
    end
    if (started) begin
      mode_m = mode;
      t_m = 1;
    end else begin
      t_m++;
    end
  endtask

  // One run: start pulse, then len cycles; abort is forced on the last cycle.
  task automatic run_case(input bit [1:0] md, input int len, input int halt_en,
                          input int abort_en, input logic [63:0] step_mask, input bit rnd,
                          input bit start_abort, input int start_t, input int rst_at);
    @(negedge clk);
    for (int d = 0; d < 3; d++) en_seen[d] = 0;
    check_cycle();
    rand_cpu();
    start = 1'b1;  mode = md;  abort = start_abort;  step = 1'b0;
    update();
    @(posedge clk);
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      check_cycle();
      if (rst_at > 0 && run_m[0] && cnt_m[0] == rst_at) begin
        idle_inputs();
        rst = 1'b1;
        #1;
        model_reset();
        check_cycle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      rand_cpu();
      if (halt_en > 0 && en_m[0] && cnt_m[0] + 1 == halt_en) begin
        inst[15:11] = 5'd0;  pc = 11'd5;  acc = 16'h0007;
      end else if (rnd && $urandom_range(15) == 0) begin
        inst[15:11] = 5'd0;
      end
      abort = (i == len) || (abort_en > 0 && en_m[1] && cnt_m[1] + 1 == abort_en) ||
              (rnd && $urandom_range(39) == 0);
      step  = (md == MStep) && (((i < 64) ? step_mask[i] : 1'b0) ||
                                (rnd && $urandom_range(2) == 0));
      start = (i == start_t) && run_m[0] && run_m[1] && run_m[2];
      update();
      @(posedge clk);
    end
    @(negedge clk);
    idle_inputs();
    check_cycle();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    mode = 2'd0;  pc = '0;  inst = 16'hFFFF;  acc = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_cycle();
    @(negedge clk);
    rst = 1'b0;

    // FREE run halting on the 6th enabled cycle.
    run_case(MFree, 15, 6, 0, 64'd0, 1'b0, 1'b0, 0, 0);
    chk("free_en_count", 0, en_seen[0], 6);
    chk("free_cycles", 0, ifa.o_cycles, 6);
    chk("free_cause", 0, 32'(ifa.o_cause), 1);
    chk("free_pc", 0, 32'(ifa.o_last_pc), 5);
    chk("free_acc", 0, 32'(ifa.o_last_acc), 32'h7);

    // LIMIT: a stops at 10; b/c continue until abort at enabled cycle 50.
    run_case(MLimit, 60, 0, 50, 64'd0, 1'b0, 1'b0, 0, 0);
    chk("limit_en_count", 0, en_seen[0], 10);
    chk("limit_cycles", 0, ifa.o_cycles, 10);
    chk("limit_cause", 0, 32'(ifa.o_cause), 2);
    chk("abort_cycles", 1, ifb.o_cycles, 50);
    chk("abort_cause", 1, 32'(ifb.o_cause), 3);

    // STEP: pulses at 4, 8, 12 and 13 (13 lands on an enabled cycle).
    run_case(MStep, 20, 0, 0, 64'h3110, 1'b0, 1'b0, 0, 0);
    chk("step_en_count", 0, en_seen[0], 3);
    chk("step_cycles", 0, ifa.o_cycles, 3);

    // HALT and abort together; start while running.
    run_case(MFree, 15, 4, 4, 64'd0, 1'b0, 1'b0, 4, 0);
    chk("halt_abort_cause", 0, 32'(ifa.o_cause), 3);
    chk("halt_abort_cycles", 0, ifa.o_cycles, 4);

    // Start together with abort from DONE.
    run_case(MFree, 10, 3, 0, 64'd0, 1'b0, 1'b1, 0, 0);
    chk("restart_cause", 0, 32'(ifa.o_cause), 1);
    chk("restart_cycles", 0, ifa.o_cycles, 3);

    // Asynchronous reset mid-run, then a fresh run counts from zero.
    run_case(MFree, 30, 0, 0, 64'd0, 1'b0, 1'b0, 0, 7);
    run_case(MFree, 12, 0, 0, 64'd0, 1'b0, 1'b0, 0, 0);
    chk("after_rst_cycles", 1, ifb.o_cycles, 10);

    // Saturation of the 4-bit counter.
    run_case(MFree, 30, 0, 20, 64'd0, 1'b0, 1'b0, 0, 0);
    chk("sat_cycles", 2, 32'(ifc.o_cycles), 32'hF);
    chk("sat_ref_cycles", 1, ifb.o_cycles, 20);

    repeat (40) begin
      run_case(2'($urandom_range(2)), int'($urandom_range(60, 5)), 0, 0, 64'd0, 1'b1,
               ($urandom_range(3) == 0), int'($urandom_range(60, 1)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
